spike_aer_encoder: RTL

//  Reader side of the neuron spike interface: samples per-cycle spike pulses from N LIF neurons
//  and turns each one into an address-event (neuron address + timestep stamp).

---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_sync_fifo.sv | 50 +++++
 rtl/spike_aer_encoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: address-event payload layout and width helpers.
package snn_pkg;

  localparam int unsigned N_NEURONS_DEF = 4;
  localparam int unsigned TS_W_DEF      = 6;

  // Address width for an n-neuron array; never narrower than one bit.
  function automatic int unsigned aer_addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned AER_ADDR_W = aer_addr_w(N_NEURONS_DEF);

  typedef struct packed {
    logic [AER_ADDR_W-1:0] addr;
    logic [TS_W_DEF-1:0]   ts;
  } aer_event_t;

endpackage

// File: rtl/snn_sync_fifo.sv
// Single-clock FIFO; push while full is taken only together with a pop.
module snn_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; full+pop+push overwrites the slot being read out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike capture, fixed-priority arbitration and AER event streaming.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS  = N_NEURONS_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic [N_NEURONS-1:0]              spike_in,
  output logic                              aer_valid,
  input  logic                              aer_ready,
  output logic [aer_addr_w(N_NEURONS)-1:0]  aer_addr,
  output logic [TS_W-1:0]                   aer_ts,
  output logic [TS_W-1:0]                   ts_now,
  output logic [DROP_W-1:0]                 drop_cnt,
  output logic                              fifo_full
);

  localparam int unsigned AW    = aer_addr_w(N_NEURONS);
  localparam int unsigned CNT_W = $clog2(N_NEURONS + 1);
  localparam int unsigned SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [TS_W-1:0] ts;
  } ev_t;

  logic [N_NEURONS-1:0] pending;
  logic [TS_W-1:0]      ts_cap [N_NEURONS];
  logic                 sel_valid;
  logic [AW-1:0]        sel_idx;
  logic [N_NEURONS-1:0] sel_hot;
  logic [N_NEURONS-1:0] drop_bits;
  logic [CNT_W-1:0]     drop_num;
  logic [SUM_W-1:0]     drop_sum;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  ev_t                  push_ev;
  ev_t                  head_ev;

  // Lowest-index pending neuron wins; also works out which spikes become drops.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel_idx   = AW'(i);
      end
    end
    pop          = aer_valid && aer_ready;
    push         = sel_valid && (!fifo_full || pop);
    sel_hot      = push ? (N_NEURONS'(1) << sel_idx) : '0;
    push_ev.addr = sel_idx;
    push_ev.ts   = ts_cap[sel_idx];
    drop_bits    = spike_in & pending & ~sel_hot;
    drop_num     = '0;
    for (int i = 0; i < int'(N_NEURONS); i++) drop_num = drop_num + CNT_W'(drop_bits[i]);
    drop_sum     = SUM_W'(drop_cnt) + SUM_W'(drop_num);
  end

  // Timestamp counter, saturating drop counter and per-neuron capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_now   <= '0;
      drop_cnt <= '0;
      pending  <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) ts_cap[i] <= '0;
    end else begin
      if (tick) ts_now <= ts_now + TS_W'(1);
      drop_cnt <= (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : DROP_W'(drop_sum);
      pending  <= spike_in | (pending & ~sel_hot);
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        if (spike_in[i] && (!pending[i] || sel_hot[i])) ts_cap[i] <= ts_now;
      end
    end
  end

  snn_sync_fifo #(
    .WIDTH ($bits(ev_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_ev),
    .pop     (pop),
    .rd_data (head_ev),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign aer_valid = !fifo_empty;
  assign aer_addr  = head_ev.addr;
  assign aer_ts    = head_ev.ts;

endmodule
